// File: rtl/beamformer_pkg.sv
// Shared beamformer front-end definitions: sequencer FSM states and the
// default channel/width configuration used by the sequencer and the filter wrapper.
package beamformer_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } seq_state_e;

    localparam int FILT_ERR_W = 2;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIN_W  = 16;
    localparam int DEF_DOUT_W = 111;

endpackage

// File: rtl/fir_sample_bank.sv
// Per-channel sample slots with pending bits and sticky overrun flags.
// A write to a channel being issued in the same cycle is accepted, not an overrun.
module fir_sample_bank
    import beamformer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIN_W  = DEF_DIN_W,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*DIN_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]       wr_stb,
    input  logic [CH_W-1:0]         issue_idx,
    input  logic                    issue_clr,
    input  logic [CH_W-1:0]         sel_idx,
    output logic [NUM_CH-1:0]       pending,
    output logic [DIN_W-1:0]        sel_data,
    output logic [NUM_CH-1:0]       overrun
);

    logic [DIN_W-1:0]  slot_r [NUM_CH];
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] overrun_r;
    logic [NUM_CH-1:0] clr_s;

    // Decode the issue-clear strobe to a one-hot per-channel clear.
    always_comb begin
        clr_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            clr_s[k] = issue_clr && (issue_idx == CH_W'(k));
        end
    end

    // Slot write, pending set/clear and overrun capture per channel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r <= '0;
            overrun_r <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                slot_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_stb[k] && (!pending_r[k] || clr_s[k])) begin
                    slot_r[k]    <= wr_data[k*DIN_W +: DIN_W];
                    pending_r[k] <= 1'b1;
                end else if (wr_stb[k]) begin
                    overrun_r[k] <= 1'b1;
                end else if (clr_s[k]) begin
                    pending_r[k] <= 1'b0;
                end else begin
                    pending_r[k] <= pending_r[k];
                end
            end
        end
    end

    assign pending  = pending_r;
    assign overrun  = overrun_r;
    assign sel_data = slot_r[sel_idx];

endmodule

// File: rtl/fir_channel_sequencer.sv
// Time-multiplexes one interleaved FIR core across NUM_CH channels: banks a
// sample per channel, issues them in channel order, and tags filter results.
module fir_channel_sequencer
    import beamformer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIN_W  = DEF_DIN_W,
    parameter int DOUT_W = DEF_DOUT_W,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*DIN_W-1:0] ch_data_in,
    input  logic [NUM_CH-1:0]       ch_valid,
    output logic [DIN_W-1:0]        filt_sink_data,
    output logic                    filt_sink_valid,
    output logic [FILT_ERR_W-1:0]   filt_sink_error,
    input  logic [DOUT_W-1:0]       filt_source_data,
    input  logic                    filt_source_valid,
    input  logic [FILT_ERR_W-1:0]   filt_source_error,
    output logic [DOUT_W-1:0]       out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    output logic                    out_frame_done,
    output logic [NUM_CH-1:0]       overrun,
    output logic                    filt_err
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    seq_state_e        state_r, state_next_s;
    logic [CH_W-1:0]   i_r, i_next_s;
    logic [CH_W-1:0]   o_r;
    logic [NUM_CH-1:0] pending_s;
    logic [DIN_W-1:0]  sel_data_s;
    logic              issue_clr_s;
    logic [DIN_W-1:0]  sink_data_r;
    logic              sink_valid_r;
    logic [DOUT_W-1:0] out_data_r;
    logic [CH_W-1:0]   out_ch_r;
    logic              out_valid_r;
    logic              frame_done_r;
    logic              filt_err_r;

    assign issue_clr_s = (state_r == ISSUE);

    // The bank reads ahead at i_next so the sink registers line up with the issue cycle.
    fir_sample_bank #(
        .NUM_CH (NUM_CH),
        .DIN_W  (DIN_W),
        .CH_W   (CH_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (ch_data_in),
        .wr_stb    (ch_valid),
        .issue_idx (i_r),
        .issue_clr (issue_clr_s),
        .sel_idx   (i_next_s),
        .pending   (pending_s),
        .sel_data  (sel_data_s),
        .overrun   (overrun)
    );

    // Next-state and issue-counter logic.
    always_comb begin
        state_next_s = state_r;
        i_next_s     = i_r;
        case (state_r)
            COLLECT: begin
                if (&pending_s) begin
                    state_next_s = ISSUE;
                    i_next_s     = '0;
                end else begin
                    state_next_s = COLLECT;
                    i_next_s     = '0;
                end
            end
            ISSUE: begin
                if (i_r == LAST_IDX) begin
                    state_next_s = COLLECT;
                    i_next_s     = '0;
                end else begin
                    state_next_s = ISSUE;
                    i_next_s     = i_r + 1'b1;
                end
            end
            default: begin
                state_next_s = COLLECT;
                i_next_s     = '0;
            end
        endcase
    end

    // State, counter and registered filter-sink drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= COLLECT;
            i_r          <= '0;
            sink_valid_r <= 1'b0;
            sink_data_r  <= '0;
        end else begin
            state_r      <= state_next_s;
            i_r          <= i_next_s;
            sink_valid_r <= (state_next_s == ISSUE);
            if (state_next_s == ISSUE) begin
                sink_data_r <= sel_data_s;
            end else begin
                sink_data_r <= '0;
            end
        end
    end

    // Output tagger: counts filter beats independently of the issue FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_r          <= '0;
            out_data_r   <= '0;
            out_ch_r     <= '0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            filt_err_r   <= 1'b0;
        end else begin
            if (filt_source_valid) begin
                out_data_r   <= filt_source_data;
                out_ch_r     <= o_r;
                out_valid_r  <= 1'b1;
                frame_done_r <= (o_r == LAST_IDX);
                o_r          <= (o_r == LAST_IDX) ? '0 : o_r + 1'b1;
            end else begin
                out_valid_r  <= 1'b0;
                frame_done_r <= 1'b0;
            end
            if (filt_source_valid && (filt_source_error != {FILT_ERR_W{1'b0}})) begin
                filt_err_r <= 1'b1;
            end else begin
                filt_err_r <= filt_err_r;
            end
        end
    end

    assign filt_sink_data  = sink_data_r;
    assign filt_sink_valid = sink_valid_r;
    assign filt_sink_error = {FILT_ERR_W{1'b0}};
    assign out_data        = out_data_r;
    assign out_ch          = out_ch_r;
    assign out_valid       = out_valid_r;
    assign out_frame_done  = frame_done_r;
    assign filt_err        = filt_err_r;

endmodule

// File: tb/tb_fir_channel_sequencer.sv
// Directed bench for fir_channel_sequencer with a 10-stage echo model of the filter.
module tb_fir_channel_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   ch_data_in;
    logic [3:0]    ch_valid;
    logic [15:0]   filt_sink_data;
    logic          filt_sink_valid;
    logic [1:0]    filt_sink_error;
    logic [110:0]  filt_source_data;
    logic          filt_source_valid;
    logic [1:0]    filt_source_error;
    logic [110:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_frame_done;
    logic [3:0]    overrun;
    logic          filt_err;

    int checks = 0;
    int errors = 0;
    int exp_o  = 0;

    logic [9:0]  pipe_v;
    logic [15:0] pipe_d [10];
    logic        mock_en;
    logic        man_v;
    logic [15:0] man_d;
    logic [1:0]  man_err;

    always #5 clk = ~clk;

    fir_channel_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .ch_data_in        (ch_data_in),
        .ch_valid          (ch_valid),
        .filt_sink_data    (filt_sink_data),
        .filt_sink_valid   (filt_sink_valid),
        .filt_sink_error   (filt_sink_error),
        .filt_source_data  (filt_source_data),
        .filt_source_valid (filt_source_valid),
        .filt_source_error (filt_source_error),
        .out_data          (out_data),
        .out_ch            (out_ch),
        .out_valid         (out_valid),
        .out_frame_done    (out_frame_done),
        .overrun           (overrun),
        .filt_err          (filt_err)
    );

    // Filter model: echoes sink beats zero-extended after 10 cycles, shares rst.
    always @(posedge clk) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int i = 0; i < 10; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v    <= {pipe_v[8:0], filt_sink_valid};
            pipe_d[0] <= filt_sink_data;
            for (int i = 1; i < 10; i++) pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign filt_source_valid = mock_en ? pipe_v[9] : man_v;
    assign filt_source_data  = mock_en ? {95'd0, pipe_d[9]} : {95'd0, man_d};
    assign filt_source_error = mock_en ? 2'b00 : man_err;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input logic [63:0] d);
        ch_data_in = d;
        ch_valid   = 4'hF;
        step();
        ch_valid   = 4'h0;
    endtask

    task automatic check_sink(input string name, input logic [15:0] exp_d);
        checks++;
        if (filt_sink_valid !== 1'b1 || filt_sink_data !== exp_d) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h",
                     name, filt_sink_valid, filt_sink_data, exp_d);
        end
    endtask

    task automatic collect_outputs(input string name, input logic [127:0] exp_vals, input int n);
        int got;
        got = 0;
        for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
            step();
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== {95'd0, exp_vals[got*16 +: 16]} || out_ch !== 2'(exp_o)
                    || out_frame_done !== (exp_o == 3)) begin
                    errors++;
                    $display("FAIL %s beat %0d: got data=%h ch=%0d done=%b, want data=%h ch=%0d done=%b",
                             name, got, out_data[15:0], out_ch, out_frame_done,
                             exp_vals[got*16 +: 16], exp_o, (exp_o == 3));
                end
                exp_o = (exp_o + 1) % 4;
                got++;
            end else begin
                checks++;
                if (out_frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s: out_frame_done=%b without out_valid, want 0", name, out_frame_done);
                end
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats, want %0d", name, got, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; ch_valid = 4'h0; ch_data_in = '0;
        mock_en = 1'b1; man_v = 1'b0; man_d = '0; man_err = 2'b00;
        repeat (3) step();
        checks++;
        if ({filt_sink_valid, filt_sink_data, out_valid, out_frame_done, out_data, out_ch,
             overrun, filt_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sink_v=%b sink_d=%h out_v=%b done=%b out_d=%h ch=%0d ovr=%b err=%b, want all 0",
                     filt_sink_valid, filt_sink_data, out_valid, out_frame_done, out_data[15:0],
                     out_ch, overrun, filt_err);
        end
        checks++;
        if (filt_sink_error !== 2'b00) begin
            errors++;
            $display("FAIL sink_error: got %b want 00", filt_sink_error);
        end
        rst = 1'b1;
        step();
        checks++;
        if (filt_sink_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: sink_v=%b out_v=%b want 0 0", filt_sink_valid, out_valid);
        end
    endtask

    task automatic test_issue_order;
        logic [15:0] v;
        for (int c = 0; c < 4; c++) begin
            v = 16'(c + 1);
            ch_data_in = '0;
            ch_data_in[c*16 +: 16] = v;
            ch_valid = 4'b0001 << c;
            step();
        end
        ch_valid = 4'h0;
        checks++;
        if (filt_sink_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_early: sink_valid=%b at t+1, want 0", filt_sink_valid);
        end
        for (int j = 0; j < 6; j++) begin
            step();
            if (j < 4) begin
                check_sink("issue_order", 16'(j + 1));
            end else begin
                checks++;
                if (filt_sink_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL issue_extra j=%0d: sink_valid=%b want 0", j, filt_sink_valid);
                end
            end
        end
    endtask

    task automatic test_output_tagging;
        collect_outputs("tag_frame1", {64'd0, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4);
        fill_frame({16'h0008, 16'h0007, 16'h0006, 16'h0005});
        collect_outputs("tag_frame2", {64'd0, 16'h0008, 16'h0007, 16'h0006, 16'h0005}, 4);
    endtask

    task automatic test_overrun;
        ch_data_in = {16'h0000, 16'h00AA, 16'h0011, 16'h0010};
        ch_valid   = 4'b0111;
        step();
        ch_data_in[32 +: 16] = 16'h00BB;
        ch_valid   = 4'b0100;
        step();
        checks++;
        if (overrun !== 4'b0100) begin
            errors++;
            $display("FAIL overrun_flag: got %b want 0100", overrun);
        end
        ch_data_in[48 +: 16] = 16'h0013;
        ch_valid   = 4'b1000;
        step();
        ch_valid   = 4'h0;
        step(); check_sink("ovr_ch0", 16'h0010);
        step(); check_sink("ovr_ch1", 16'h0011);
        step(); check_sink("ovr_ch2_keeps_old", 16'h00AA);
        step(); check_sink("ovr_ch3", 16'h0013);
        collect_outputs("ovr_frame", {64'd0, 16'h0013, 16'h00AA, 16'h0011, 16'h0010}, 4);
    endtask

    task automatic test_same_cycle_refill;
        fill_frame({16'h0024, 16'h0023, 16'h0022, 16'h0021});
        step(); check_sink("same_a0", 16'h0021);
        ch_data_in = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
        ch_valid   = 4'b0001;
        step();
        ch_valid   = 4'h0;
        check_sink("same_a1", 16'h0022);
        checks++;
        if (overrun !== 4'b0100) begin
            errors++;
            $display("FAIL same_cycle_overrun: got %b want 0100", overrun);
        end
        step(); check_sink("same_a2", 16'h0023);
        step(); check_sink("same_a3", 16'h0024);
        step();
        ch_data_in = {16'h0033, 16'h0032, 16'h0031, 16'hDEAD};
        ch_valid   = 4'b1110;
        step();
        ch_valid   = 4'h0;
        step(); check_sink("same_b0_refilled", 16'h1234);
        step(); check_sink("same_b1", 16'h0031);
        step(); check_sink("same_b2", 16'h0032);
        step(); check_sink("same_b3", 16'h0033);
        checks++;
        if (overrun !== 4'b0100) begin
            errors++;
            $display("FAIL overrun_sticky: got %b want 0100", overrun);
        end
        collect_outputs("same_frames",
                        {16'h0033, 16'h0032, 16'h0031, 16'h1234, 16'h0024, 16'h0023, 16'h0022, 16'h0021}, 8);
    endtask

    task automatic test_filt_err;
        checks++;
        if (filt_err !== 1'b0) begin
            errors++;
            $display("FAIL filt_err_clean: got %b want 0", filt_err);
        end
        mock_en = 1'b0;
        man_v = 1'b1; man_d = 16'h0ABC; man_err = 2'b01;
        step();
        man_v = 1'b0; man_d = 16'h0000; man_err = 2'b00;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {95'd0, 16'h0ABC} || out_ch !== 2'(exp_o)
            || filt_err !== 1'b1) begin
            errors++;
            $display("FAIL filt_err_beat: got v=%b d=%h ch=%0d err=%b, want v=1 d=0abc ch=%0d err=1",
                     out_valid, out_data[15:0], out_ch, filt_err, exp_o);
        end
        exp_o = (exp_o + 1) % 4;
        step();
        checks++;
        if (out_valid !== 1'b0 || filt_err !== 1'b1) begin
            errors++;
            $display("FAIL filt_err_sticky: got v=%b err=%b, want v=0 err=1", out_valid, filt_err);
        end
        mock_en = 1'b1;
    endtask

    task automatic test_reset_mid_issue;
        fill_frame({16'h0054, 16'h0053, 16'h0052, 16'h0051});
        step(); step(); step();
        check_sink("mid_i2", 16'h0053);
        rst = 1'b0;
        step();
        exp_o = 0;
        checks++;
        if ({filt_sink_valid, filt_sink_data, out_valid, out_frame_done, out_data, out_ch,
             overrun, filt_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset: sink_v=%b sink_d=%h out_v=%b done=%b ch=%0d ovr=%b err=%b, want all 0",
                     filt_sink_valid, filt_sink_data, out_valid, out_frame_done, out_ch, overrun, filt_err);
        end
        rst = 1'b1;
        for (int j = 0; j < 14; j++) begin
            step();
            checks++;
            if (filt_sink_valid !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL residual j=%0d: sink_v=%b out_v=%b want 0 0", j, filt_sink_valid, out_valid);
            end
        end
        fill_frame({16'h0044, 16'h0043, 16'h0042, 16'h0041});
        step(); check_sink("post_rst_ch0", 16'h0041);
        step(); check_sink("post_rst_ch1", 16'h0042);
        step(); check_sink("post_rst_ch2", 16'h0043);
        step(); check_sink("post_rst_ch3", 16'h0044);
        collect_outputs("post_rst_out", {64'd0, 16'h0044, 16'h0043, 16'h0042, 16'h0041}, 4);
    endtask

    initial begin
        test_reset();
        test_issue_order();
        test_output_tagging();
        test_overrun();
        test_same_cycle_refill();
        test_filt_err();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_channel_sequencer.md
# fir_channel_sequencer

Time-multiplexes one interleaved-channel band-pass FIR core (Avalon-ST sink/source, `BP_Filt` instance) across NUM_CH microphone channels of the beamformer front end. Per-channel samples arrive asynchronously within a frame period. They are banked until every channel has one sample, then issued to the filter in strict channel order 0..NUM_CH-1 on consecutive cycles. Filtered results are tagged with their channel index on the way out. Overrun and filter-error conditions are reported as sticky flags.

## Interface
Parameters:
- NUM_CH, 4, channels sharing the filter; the filter core is configured for the same count; ≥2
- DIN_W, 16, sample width per channel
- DOUT_W, 111, filter output width
- CH_W, $clog2(NUM_CH), channel tag width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-low
- ch_data_in  in  NUM_CH*DIN_W  channel k at bits [k*DIN_W +: DIN_W]
- ch_valid  in  NUM_CH  one-cycle strobe per channel: new sample present
- filt_sink_data  out  DIN_W  to filter ast_sink_data
- filt_sink_valid  out  1  to filter ast_sink_valid
- filt_sink_error  out  2  to filter ast_sink_error; constant 2'b00
- filt_source_data  in  DOUT_W  from filter ast_source_data
- filt_source_valid  in  1  from filter ast_source_valid
- filt_source_error  in  2  from filter ast_source_error
- out_data  out  DOUT_W  registered filtered sample
- out_ch  out  CH_W  channel of out_data
- out_valid  out  1  one-cycle strobe: out_data/out_ch valid
- out_frame_done  out  1  one-cycle strobe coincident with out_valid for channel NUM_CH-1
- overrun  out  NUM_CH  sticky per-channel overrun flag
- filt_err  out  1  sticky: filter reported a non-zero error

## Operation
- Sample bank: one DIN_W slot plus a pending bit per channel. A ch_valid[k] strobe with pending[k]=0 writes the slot and sets pending[k].
- Overrun: ch_valid[k] with pending[k]=1 and slot k not being issued in that cycle drops the new sample (slot keeps old value) and sets overrun[k].
- FSM states:
  - COLLECT: the default after reset. Moves to ISSUE when every pending bit is 1 at a clock edge. A strobe arriving in that same cycle is treated as an overrun.
  - ISSUE: issue counter i runs 0..NUM_CH-1, one cycle each. Drives filt_sink_data=slot[i] and filt_sink_valid=1, and clears pending[i] at the end of that cycle. After i=NUM_CH-1, returns to COLLECT and i resets to 0.
- ch_valid[k] in the same cycle that channel k is issued is accepted. The clear and the new write resolve to pending[k]=1 holding the new value, with no overrun. ch_valid[k] after channel k has been issued also refills normally.
- filt_sink_valid is never high outside ISSUE. Exactly NUM_CH consecutive valid cycles occur per frame.
- Output tagging: the output counter o starts at 0. Each filt_source_valid registers out_data=filt_source_data and out_ch=o, pulses out_valid, then increments o (NUM_CH-1 wraps to 0). out_frame_done pulses when o==NUM_CH-1.
- filt_source_error≠0 while filt_source_valid sets filt_err. The data is still forwarded.
- Sticky flags clear only on reset.

## Timing
- Reset (rst=0 at an edge) values:
  - all outputs 0: filt_sink_valid, filt_sink_data, out_valid, out_frame_done, out_data, out_ch, overrun, filt_err
  - pending bits 0, counters i and o 0
  - state COLLECT
- The filter shares rst. Reset mid-ISSUE or mid-output discards the partial frame; no residual pulses follow reset release.
- Issue latency: last missing sample strobed at cycle t gives filt_sink_valid for ch0 at t+2 and ch NUM_CH-1 at t+1+NUM_CH.
  - t+1: pending full, FSM enters ISSUE.
  - filt_sink_* are registered outputs.
- Output latency: out_valid is asserted one cycle after filt_source_valid.
- filt_source_valid is independent of the FSM; outputs may overlap the next frame's COLLECT or ISSUE.
- Minimum frame period NUM_CH+1 cycles; sustained faster input produces overruns.

## Structure
- Shared package `beamformer_pkg`: FSM state typedef (COLLECT, ISSUE), FILT_ERR_W=2 constant, default NUM_CH/DIN_W/DOUT_W localparams shared with the filter wrapper.
- One sub-module, `fir_sample_bank`: per-channel slots, pending bits, overrun logic. Interface: write strobes, issue index, issue-clear strobe, pending vector, selected slot data.
- FSM, issue counter and output tagger stay in the top.

## Test plan
- Reset, NUM_CH=4: strobe ch0..ch3 with 0x0001..0x0004 on cycles 0..3 → filt_sink_valid cycles 5..8 carrying 0x0001..0x0004 in order; all outputs 0 before stimulus.
- Mocked filter echoes sink data zero-extended after 10 cycles → out_valid ×4 with out_ch 0,1,2,3; out_frame_done only with out_ch=3; second frame wraps out_ch to 0.
- ch2 strobed twice (0x00AA then 0x00BB) before ch3 arrives → overrun=4'b0100; ch2 issues 0x00AA; flag persists across later frames.
- ch0 strobed 0x1234 in the exact cycle ch0 is issued → no overrun; next frame issues ch0=0x1234.
- filt_source_error=2'b01 on one source beat → filt_err=1 sticky, that beat still forwarded with correct out_ch.
- rst=0 asserted during ISSUE at i=2 → next edge: filt_sink_valid=0, pending=0, out_* =0; new full frame after release issues from ch0.
